// File: rtl/a2d_spi_slave_if.sv
// SPI pin bundle between the throttle reader (master) and the A2D model (slave).
interface a2d_spi_slave_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_slave.sv
// ADC128S-style 8-channel, 12-bit A2D model on an SPI slave port, one-frame result pipeline.
// Optional malformed-command detection is enabled by defining A2D_CMD_CHECK_EN.
module a2d_spi_slave #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned RES_W    = 12,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  a2d_spi_slave_if.slave          spi,
  input  logic [NUM_CH*RES_W-1:0] ch_vals,
  output logic [2:0]              last_ch,
  output logic [7:0]              frm_cnt,
  output logic                    cmd_err
);

  localparam int unsigned FRM_W = 16;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned CH_W  = 3;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [FRM_W-1:0]    r_tx_shft, w_tx_nxt;
  logic [FRM_W-1:0]    r_rx_shft, w_rx_nxt;
  logic [CH_W-1:0]     r_last_ch, w_last_ch_nxt;
  logic [7:0]          r_frm_cnt, w_frm_cnt_nxt;
  logic                w_miso_c;

  logic [SYNC_STG-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic                r_ss_prev, r_sclk_prev;
  logic                w_ss, w_sclk, w_mosi;
  logic                w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall;
  logic [RES_W-1:0]    w_ch_val [NUM_CH];

  // Pin synchronizers; SS_n/SCLK idle high so they reset high to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '1;
      r_mosi_sync <= '0;
      r_ss_prev   <= 1'b1;
      r_sclk_prev <= 1'b1;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STG-2:0],   spi.SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], spi.SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], spi.MOSI};
      r_ss_prev   <= w_ss;
      r_sclk_prev <= w_sclk;
    end
  end

  assign w_ss        = r_ss_sync[SYNC_STG-1];
  assign w_sclk      = r_sclk_sync[SYNC_STG-1];
  assign w_mosi      = r_mosi_sync[SYNC_STG-1];
  assign w_ss_fall   =  r_ss_prev   & ~w_ss;
  assign w_ss_rise   = ~r_ss_prev   &  w_ss;
  assign w_sclk_rise = ~r_sclk_prev &  w_sclk;
  assign w_sclk_fall =  r_sclk_prev & ~w_sclk;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_val[g] = ch_vals[g*RES_W +: RES_W];
  end

`ifdef A2D_CMD_CHECK_EN
  logic r_cmd_err, w_cmd_err_nxt;
  logic w_cmd_bad;

  // Anything outside the 3-bit channel field must be zero in a well-formed command.
  assign w_cmd_bad = (|r_rx_shft[15:14]) | (|r_rx_shft[10:0]);
`else
  logic w_unused_rx_msb;

  assign w_unused_rx_msb = r_rx_shft[FRM_W-1];
`endif

  // Frame sequencing and datapath next-state.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx_shft;
    w_rx_nxt      = r_rx_shft;
    w_last_ch_nxt = r_last_ch;
    w_frm_cnt_nxt = r_frm_cnt;
    w_miso_c      = 1'b0;
`ifdef A2D_CMD_CHECK_EN
    w_cmd_err_nxt = r_cmd_err;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_nxt   = ACTIVE;
          w_tx_nxt      = FRM_W'(w_ch_val[r_last_ch]);
          w_bit_cnt_nxt = '0;
        end
      end
      ACTIVE: begin
        w_miso_c = r_tx_shft[FRM_W-1];
        // SS_n rise wins over a coincident SCLK edge.
        if (w_ss_rise) begin
          w_state_nxt = DONE;
        end else if (w_sclk_rise) begin
          w_rx_nxt = {r_rx_shft[FRM_W-2:0], w_mosi};
          if (r_bit_cnt != CNT_W'(FRM_W)) begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
          // The leading fall before any rise keeps bit 15 on MISO.
          w_tx_nxt = {r_tx_shft[FRM_W-2:0], 1'b0};
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (r_bit_cnt == CNT_W'(FRM_W)) begin
          w_last_ch_nxt = r_rx_shft[13:11];
          w_frm_cnt_nxt = r_frm_cnt + 8'd1;
`ifdef A2D_CMD_CHECK_EN
          if (w_cmd_bad) begin
            w_cmd_err_nxt = 1'b1;
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_tx_shft <= '0;
      r_rx_shft <= '0;
      r_last_ch <= '0;
      r_frm_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx_shft <= w_tx_nxt;
      r_rx_shft <= w_rx_nxt;
      r_last_ch <= w_last_ch_nxt;
      r_frm_cnt <= w_frm_cnt_nxt;
    end
  end

`ifdef A2D_CMD_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_err <= 1'b0;
    end else begin
      r_cmd_err <= w_cmd_err_nxt;
    end
  end

  assign cmd_err = r_cmd_err;
`else
  assign cmd_err = 1'b0;
`endif

  assign spi.MISO = w_miso_c;
  assign last_ch  = r_last_ch;
  assign frm_cnt  = r_frm_cnt;

endmodule

// File: tb/tb_a2d_spi_slave.sv
// Scoreboard bench for a2d_spi_slave: a master task issues frames and queues expectations,
// an independent SPI monitor collects MISO words and checks them with the frame status.
module tb_a2d_spi_slave;

`ifdef A2D_CMD_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        chk;
    logic [15:0] resp;
    logic [2:0]  lch;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [95:0] ch_vals;
  logic [2:0]  last_ch;
  logic [7:0]  frm_cnt;
  logic        cmd_err;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  a2d_spi_slave_if bus ();

  a2d_spi_slave #(.NUM_CH(8), .RES_W(12), .SYNC_STG(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (bus),
    .ch_vals (ch_vals),
    .last_ch (last_ch),
    .frm_cnt (frm_cnt),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Master: sends word[nbits-1:0] MSB first; optionally rewrites ch4 after bit chg_at.
  task automatic spi_frame(input logic [23:0] word, input int nbits, input logic c,
                           input logic [15:0] resp, input logic [2:0] lch,
                           input logic [7:0] cnt, input logic err, input int chg_at);
    exp_t e;
    e = '{chk: c, resp: resp, lch: lch, cnt: cnt, err: err};
    sb_q.push_back(e);
    @(negedge clk) bus.SS_n = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.SCLK = 1'b0;
      bus.MOSI = word[i];
      repeat (32) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (32) @(negedge clk);
      if (nbits - 1 - i == chg_at) ch_vals[59:48] = 12'h001;
    end
    bus.SS_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  // Monitor: collects the first 16 MISO bits of each SS_n-low window.
  initial begin
    logic [15:0] m_word;
    int          m_bits;
    exp_t        e;
    forever begin
      @(negedge bus.SS_n);
      m_word = '0;
      m_bits = 0;
      while (bus.SS_n == 1'b0) begin
        @(posedge bus.SCLK or posedge bus.SS_n);
        if (!bus.SS_n && m_bits < 16) begin
          m_word = {m_word[14:0], bus.MISO};
          m_bits++;
        end
      end
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_underflow: got frame with empty queue expected queued entry");
      end else begin
        e = sb_q.pop_front();
        if (e.chk) begin
          chk("resp_bits", 32'(m_bits), 32'd16);
          chk("resp", 32'(m_word), 32'(e.resp));
        end
        repeat (10) @(negedge clk);
        chk("last_ch", 32'(last_ch), 32'(e.lch));
        chk("frm_cnt", 32'(frm_cnt), 32'(e.cnt));
        chk("cmd_err", 32'(cmd_err), 32'(e.err));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    bus.SS_n = 1'b1;
    bus.SCLK = 1'b1;
    bus.MOSI = 1'b0;
    ch_vals  = {12'hFFF, 12'h6D6, 12'h5C5, 12'hABC, 12'h3B3, 12'h2A2, 12'h555, 12'h123};
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    chk("rst_miso", 32'(bus.MISO), 32'd0);
    chk("rst_last_ch", 32'(last_ch), 32'd0);
    chk("rst_frm_cnt", 32'(frm_cnt), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);

    // Pipeline: response reflects the previous frame's channel.
    spi_frame(24'h2000, 16, 1'b1, 16'h0123, 3'd4, 8'd1, 1'b0, -1);
    spi_frame(24'h2000, 16, 1'b1, 16'h0ABC, 3'd4, 8'd2, 1'b0, -1);
    spi_frame(24'h0800, 16, 1'b1, 16'h0ABC, 3'd1, 8'd3, 1'b0, -1);
    spi_frame(24'h3800, 16, 1'b1, 16'h0555, 3'd7, 8'd4, 1'b0, -1);
    spi_frame(24'h0800, 16, 1'b1, 16'h0FFF, 3'd1, 8'd5, 1'b0, -1);
    spi_frame(24'h3800, 16, 1'b1, 16'h0555, 3'd7, 8'd6, 1'b0, -1);

    // Aborted frame: first 9 bits of 0x1000.
    spi_frame(24'h000020, 9, 1'b0, 16'h0000, 3'd7, 8'd6, 1'b0, -1);
    spi_frame(24'h2000, 16, 1'b1, 16'h0FFF, 3'd4, 8'd7, 1'b0, -1);

    // ch4 changes mid-frame; the frame in flight keeps the old value.
    spi_frame(24'h2000, 16, 1'b1, 16'h0ABC, 3'd4, 8'd8, 1'b0, 8);
    spi_frame(24'h0000, 16, 1'b1, 16'h0001, 3'd0, 8'd9, 1'b0, -1);

    // Malformed command, then a valid one: flag is sticky when checking is built in.
    spi_frame(24'h2001, 16, 1'b1, 16'h0123, 3'd4, 8'd10, ERR_EN, -1);
    spi_frame(24'h0800, 16, 1'b1, 16'h0001, 3'd1, 8'd11, ERR_EN, -1);

    // 17 SCLK periods: the last 16 rx bits (0x3000 -> ch6) win.
    spi_frame(24'h013000, 17, 1'b1, 16'h0555, 3'd6, 8'd12, ERR_EN, -1);
    spi_frame(24'h0000, 16, 1'b1, 16'h06D6, 3'd0, 8'd13, ERR_EN, -1);

    // Reset in the middle of a frame.
    sb_q.push_back('{chk: 1'b0, resp: 16'h0, lch: 3'd0, cnt: 8'd0, err: 1'b0});
    @(negedge clk) bus.SS_n = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.SCLK = 1'b0;
      bus.MOSI = 1'b1;
      repeat (32) @(negedge clk);
      bus.SCLK = 1'b1;
      repeat (32) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_frm_cnt", 32'(frm_cnt), 32'd0);
    chk("midrst_last_ch", 32'(last_ch), 32'd0);
    chk("midrst_miso", 32'(bus.MISO), 32'd0);
    chk("midrst_cmd_err", 32'(cmd_err), 32'd0);
    rst_n = 1'b1;
    repeat (32) @(negedge clk);
    bus.SS_n = 1'b1;
    repeat (40) @(negedge clk);
    spi_frame(24'h0000, 16, 1'b1, 16'h0123, 3'd0, 8'd1, 1'b0, -1);

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
